// File: rtl/mc_control_unit.sv
// mc_control_unit -- multicycle control FSM for the 16-bit RISC core.
//
// This block decodes the IR opcode and drives the datapath selects and strobes
// one state at a time. The memory port uses a ready/wait handshake. A wait that
// lasts too long sends the FSM to the ERROR state. HALT and ERROR are terminal
// states that only reset leaves. A counter tracks how many instructions have
// retired.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   opcode             IR[15:12]; stable from the cycle after an IR write
//   zero               ALU zero flag (used by BEQ/BNEZ)
//   mem_ready          memory accepted/returned the access this cycle
//   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//   ir_write, pc_write, pc_src, mem_read, mem_write   datapath controls
//   state              current state encoding
//   halted, error      terminal state flags
//   retired_count      instructions retired since reset (wraps)
module mc_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 8,
  parameter int WAIT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [3:0]          state,
  output logic                halted,
  output logic                error,
  output logic [CNT_W-1:0]    retired_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I = 4'd3,
    ALU_WB   = 4'd4,  MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7,
    MEM_WR   = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, HALT   = 4'd11,
    ERROR    = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BNEZ = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);
  localparam logic [WAIT_W-1:0]   TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_inc;
  logic [CNT_W-1:0]   retired_reg;
  logic               wait_state;
  logic               wait_expire;
  logic               retire;

  // Decoded controls before the reset gate.
  logic       reg_write_d, mem_to_reg_d, alu_src_a_d, ir_write_d, pc_write_d;
  logic       mem_read_d, mem_write_d, halted_d, error_d;
  logic [1:0] alu_src_b_d, alu_op_d, pc_src_d;

  assign wait_state   = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);
  assign wait_cnt_inc = wait_cnt_reg + 1'b1;
  // The TIMEOUT-th consecutive not-ready cycle is the last one allowed.
  // A ready in that same cycle still takes the normal path.
  assign wait_expire  = (TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt_inc == TIMEOUT_CNT);

  // State register, wait counter and retirement counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg <= state_next;
      // The counter is zero on every entry to a wait state: any other cycle
      // (non-wait state, or a ready cycle) clears it.
      if (wait_state && !mem_ready)
        wait_cnt_reg <= wait_cnt_inc;
      else
        wait_cnt_reg <= '0;
      if (retire)
        retired_reg <= retired_reg + 1'b1;
    end
  end

  // Next-state logic and the retirement condition.
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (opcode < OP_LW)                            state_next = EXEC_R;
        else if (opcode == OP_ADDI)                    state_next = EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)   state_next = MEM_ADDR;
        else if (opcode == OP_BNEZ || opcode == OP_BEQ) state_next = BRANCH;
        else if (opcode == OP_JMP)                     state_next = JUMP;
        else if (opcode == OP_HALT) begin
          state_next = HALT;
          retire     = 1'b1;
        end else                                       state_next = ERROR;
      end
      EXEC_R, EXEC_I: state_next = ALU_WB;
      MEM_ADDR: state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
      MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      ALU_WB, MEM_WB, BRANCH, JUMP: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      HALT:     state_next = HALT;
      default:  state_next = ERROR;  // ERROR and the unused codes 13-15
    endcase
    // Timeout only happens when mem_ready is low, so no retirement can be lost here.
    if (wait_expire)
      state_next = ERROR;
  end

  // Output decode. These are Moore outputs, except for the strobes that are
  // qualified by mem_ready or zero.
  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 2'b00;
    ir_write_d   = 1'b0;
    pc_write_d   = 1'b0;
    pc_src_d     = 2'b00;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    halted_d     = 1'b0;
    error_d      = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b01;
        ir_write_d  = mem_ready;
        pc_write_d  = mem_ready;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      EXEC_R:   alu_op_d = 2'b10;
      EXEC_I:   alu_src_b_d = 2'b10;
      ALU_WB:   reg_write_d = 1'b1;
      MEM_ADDR: alu_src_b_d = 2'b10;
      MEM_RD:   mem_read_d = 1'b1;
      MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      MEM_WR:   mem_write_d = 1'b1;
      BRANCH: begin
        alu_op_d   = 2'b01;
        pc_src_d   = 2'b01;
        pc_write_d = (opcode == OP_BEQ) ? zero : ~zero;
      end
      JUMP: begin
        pc_src_d   = 2'b10;
        pc_write_d = 1'b1;
      end
      HALT:     halted_d = 1'b1;
      ERROR:    error_d = 1'b1;
      default:  ;
    endcase
  end

  // While reset is high, every output is held at zero. FETCH would otherwise
  // drive mem_read, and a write in flight must drop at once.
  assign reg_write     = reset ? 1'b0  : reg_write_d;
  assign mem_to_reg    = reset ? 1'b0  : mem_to_reg_d;
  assign alu_src_a     = reset ? 1'b0  : alu_src_a_d;
  assign alu_src_b     = reset ? 2'b00 : alu_src_b_d;
  assign alu_op        = reset ? 2'b00 : alu_op_d;
  assign ir_write      = reset ? 1'b0  : ir_write_d;
  assign pc_write      = reset ? 1'b0  : pc_write_d;
  assign pc_src        = reset ? 2'b00 : pc_src_d;
  assign mem_read      = reset ? 1'b0  : mem_read_d;
  assign mem_write     = reset ? 1'b0  : mem_write_d;
  assign halted        = reset ? 1'b0  : halted_d;
  assign error         = reset ? 1'b0  : error_d;
  assign state         = reset ? 4'd0  : state_reg;
  assign retired_count = retired_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit. The bench builds each instruction's expected
// state walk from its opcode class and the wait cycles it chose. It then checks
// state, the control word and the retired count once per cycle.
module tb_mc_control_unit;
  localparam int CW = 4;  // small counter width so wrap-around is exercised

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_ALU_WB = 4,
                 S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WB = 7, S_MEM_WR = 8,
                 S_BRANCH = 9, S_JUMP = 10, S_HALT = 11, S_ERROR = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = 4'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          reg_write, mem_to_reg, alu_src_a, ir_write, pc_write;
  logic          mem_read, mem_write, halted, error;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic [CW-1:0] retired_count;

  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt = '0;

  mc_control_unit #(.OPCODE_W(4), .CNT_W(CW), .TIMEOUT(8), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .state(state),
    .halted(halted), .error(error), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  wire [15:0] ctrl = {reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      ir_write, pc_write, pc_src, mem_read, mem_write, halted, error};

  // Expected control word for a given state and the inputs in that cycle.
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic zr,
                                           input int op);
    logic rw = 0, m2r = 0, a = 0, irw = 0, pcw = 0, mr = 0, mw = 0, h = 0, e = 0;
    logic [1:0] b = 0, aop = 0, ps = 0;
    case (st)
      S_FETCH:    begin mr = 1; a = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   begin a = 1; b = 2'b10; end
      S_EXEC_R:   aop = 2'b10;
      S_EXEC_I:   b = 2'b10;
      S_ALU_WB:   rw = 1;
      S_MEM_ADDR: b = 2'b10;
      S_MEM_RD:   mr = 1;
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   mw = 1;
      S_BRANCH:   begin aop = 2'b01; ps = 2'b01; pcw = (op == 11) ? zr : !zr; end
      S_JUMP:     begin ps = 2'b10; pcw = 1; end
      S_HALT:     h = 1;
      S_ERROR:    e = 1;
      default:    ;
    endcase
    return {rw, m2r, a, b, aop, irw, pcw, ps, mr, mw, h, e};
  endfunction

  // One clock cycle: drive the inputs, check the outputs mid-cycle, then advance past the edge.
  task automatic step(input int st, input logic rdy, input logic zr, input string tag);
    logic [15:0] want;
    mem_ready = rdy;
    zero = zr;
    @(negedge clk);
    want = exp_ctrl(st, rdy, zr, int'(opcode));
    tests++;
    assert (state === 4'(st)) else begin
      fails++; $error("FAIL %s state got %0d want %0d", tag, state, st);
    end
    tests++;
    assert (ctrl === want) else begin
      fails++; $error("FAIL %s ctrl(st=%0d) got %h want %h", tag, st, ctrl, want);
    end
    tests++;
    assert (retired_count === exp_cnt) else begin
      fails++; $error("FAIL %s retired got %0d want %0d", tag, retired_count, exp_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;  // FETCH would assert strobes if reset did not gate them
    repeat (3) @(posedge clk);
    #1;
    tests++;
    assert (ctrl === 16'h0 && state === 4'd0 && retired_count === '0) else begin
      fails++; $error("FAIL reset_outputs got ctrl=%h st=%0d cnt=%0d want 0/0/0",
                      ctrl, state, retired_count);
    end
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  // Run one instruction: fw not-ready cycles in FETCH, mw in the memory state.
  task automatic run_instr(input int op, input logic zr, input int fw, input int mw);
    string t;
    t = $sformatf("op%0d", op);
    opcode = 4'(op);
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, zr, {t, "_fetchwait"});
    step(S_FETCH, 1'b1, zr, {t, "_fetch"});
    step(S_DECODE, 1'($urandom), zr, {t, "_decode"});
    if (op < 8 || op == 13) begin
      step(op < 8 ? S_EXEC_R : S_EXEC_I, 1'($urandom), zr, {t, "_exec"});
      step(S_ALU_WB, 1'($urandom), zr, {t, "_wb"});
      exp_cnt++;
    end else if (op == 8 || op == 9) begin
      step(S_MEM_ADDR, 1'($urandom), zr, {t, "_addr"});
      for (int i = 0; i < mw; i++) step(op == 8 ? S_MEM_RD : S_MEM_WR, 1'b0, zr, {t, "_memwait"});
      step(op == 8 ? S_MEM_RD : S_MEM_WR, 1'b1, zr, {t, "_mem"});
      if (op == 8) step(S_MEM_WB, 1'($urandom), zr, {t, "_memwb"});
      exp_cnt++;
    end else if (op == 10 || op == 11) begin
      step(S_BRANCH, 1'($urandom), zr, {t, "_branch"});
      exp_cnt++;
    end else if (op == 12) begin
      step(S_JUMP, 1'($urandom), zr, {t, "_jump"});
      exp_cnt++;
    end else if (op == 15) begin
      exp_cnt++;
    end
  endtask

  initial begin
    do_reset();

    // Directed: R-type, LW with 3 wait cycles, BEQ taken, BNEZ not taken.
    run_instr(0, 1'b0, 0, 0);
    run_instr(8, 1'b0, 0, 3);
    run_instr(11, 1'b1, 0, 0);
    run_instr(10, 1'b1, 0, 0);

    // Randomized mix of legal non-terminal instructions (counter wraps at 16).
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 13)), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    // FETCH timeout: 8 not-ready cycles lead to ERROR, which is sticky.
    do_reset();
    for (int i = 0; i < 8; i++) step(S_FETCH, 1'b0, 1'b0, "fetch_to_wait");
    for (int i = 0; i < 5; i++) step(S_ERROR, 1'($urandom), 1'b0, "fetch_to_error");

    // Ready on the 8th cycle wins over the timeout.
    do_reset();
    opcode = 4'd0;
    for (int i = 0; i < 7; i++) step(S_FETCH, 1'b0, 1'b0, "fetch_edge_wait");
    step(S_FETCH, 1'b1, 1'b0, "fetch_edge_ready");
    step(S_DECODE, 1'b0, 1'b0, "fetch_edge_decode");

    // MEM_WR timeout: the store does not retire.
    do_reset();
    run_instr(0, 1'b0, 0, 0);
    opcode = 4'd9;
    step(S_FETCH, 1'b1, 1'b0, "sw_to_fetch");
    step(S_DECODE, 1'b0, 1'b0, "sw_to_decode");
    step(S_MEM_ADDR, 1'b0, 1'b0, "sw_to_addr");
    for (int i = 0; i < 8; i++) step(S_MEM_WR, 1'b0, 1'b0, "sw_to_wait");
    for (int i = 0; i < 3; i++) step(S_ERROR, 1'b1, 1'b0, "sw_to_error");

    // HALT retires and is terminal.
    do_reset();
    run_instr(15, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) step(S_HALT, 1'($urandom), 1'($urandom), "halt_hold");

    // Illegal opcode leads to ERROR, which is terminal.
    do_reset();
    run_instr(14, 1'b0, 1, 0);
    for (int i = 0; i < 5; i++) step(S_ERROR, 1'($urandom), 1'b0, "illegal_hold");

    // Reset during MEM_WR drops mem_write before any clock edge and clears the count.
    do_reset();
    run_instr(1, 1'b0, 0, 0);
    opcode = 4'd9;
    step(S_FETCH, 1'b1, 1'b0, "rstmid_fetch");
    step(S_DECODE, 1'b0, 1'b0, "rstmid_decode");
    step(S_MEM_ADDR, 1'b0, 1'b0, "rstmid_addr");
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    assert (mem_write === 1'b1 && state === 4'(S_MEM_WR)) else begin
      fails++; $error("FAIL rstmid_pre got mw=%b st=%0d want 1/8", mem_write, state);
    end
    reset = 1'b1;
    #1;
    tests++;
    assert (mem_write === 1'b0 && state === 4'd0 && retired_count === '0) else begin
      fails++; $error("FAIL rstmid_async got mw=%b st=%0d cnt=%0d want 0/0/0",
                      mem_write, state, retired_count);
    end
    do_reset();
    run_instr(12, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
